cache_axi_refill: RTL and testbench
===================================

Name: cache_axi_refill

Overview:
- AXI-side line engine for the data cache; sits between the cache controller and the AXI master bus.
- On a miss, it writes back the dirty victim line with an 8-beat AXI write burst, if needed. It then fetches the new line with an 8-beat AXI read burst.
- It drives `refresh` and `cacheline_new` into the data array and consumes `cacheline_old` from it.
- Line is 256 bits (8 x 32-bit words); index/offset split is 7-bit index, 5-bit offset.

Parameters:
- `LINE_WORDS`, 8, words per cache line; fixes burst length (`len` = `LINE_WORDS`-1).
- `AXI_ID`, 4'd0, constant ID driven on AR/AW/W.

Ports:
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `miss` input 1 — start request, sampled only in IDLE.
- `dirty` input 1 — victim must be written back before the refill; sampled with `miss`.
- `miss_addr` input 32 — address of the missing access; low 5 bits ignored.
- `wb_addr` input 32 — victim line address; low 5 bits ignored.
- `cacheline_old` input 256 — victim line data; captured with `miss`.
- `refresh` output 1 — one-cycle pulse; `cacheline_new` valid that cycle.
- `cacheline_new` output 256 — assembled refill line; word i at bits [32i+31:32i].
- `busy` output 1 — high in every state except IDLE.
- `awid/awaddr/awlen/awsize/awburst/awvalid` output 4/32/4/3/2/1; `awready` input 1.
- `wid/wdata/wstrb/wlast/wvalid` output 4/32/4/1/1; `wready` input 1.
- `bvalid` input 1, `bresp` input 2, `bready` output 1.
- `arid/araddr/arlen/arsize/arburst/arvalid` output 4/32/4/3/2/1; `arready` input 1.
- `rdata` input 32, `rresp` input 2, `rlast` input 1, `rvalid` input 1, `rready` output 1.

Behaviour:
- **Reset:** async, state=IDLE. All valid/ready outputs, `refresh`, `busy` = 0. `cacheline_new`, captured line, addresses, beat counter = 0.
- **Constant outputs:** `awlen`=`arlen`=4'd7, `awsize`=`arsize`=3'b010, `awburst`=`arburst`=2'b01 (INCR), `wstrb`=4'hF, IDs=`AXI_ID`.
- **States:** IDLE, AW, W, B, AR, R, DONE.
- **IDLE:**
  - If `miss`=1: capture `{miss_addr[31:5],5'b0}`, `{wb_addr[31:5],5'b0}` and `cacheline_old`; clear the beat counter.
  - Next state is AW if `dirty`, else AR.
  - `miss` asserted in any other state is ignored.
- **AW:** `awvalid`=1 with `awaddr` = captured victim address, held stable until `awready`. Handshake -> W. No W beat is issued before the AW handshake, even if `wready` is high early.
- **W:**
  - `wvalid`=1, `wdata` = captured word[beat].
  - `wlast`=1 when beat==7.
  - On `wvalid`&`wready`: beat+1.
  - Beat-7 handshake -> B, counter cleared.
- **B:** `bready`=1; on `bvalid` -> AR. `bresp` is ignored.
- **AR:** `arvalid`=1 with `araddr` = captured miss line address, held until `arready`; handshake -> R.
- **R:**
  - `rready`=1.
  - On `rvalid`: `cacheline_new` word[beat] <= `rdata`, beat+1.
  - The 8th beat (counter==7) -> DONE, regardless of `rlast`.
  - `rlast` arriving early is ignored for termination. `rresp` is ignored.
- **DONE:** `refresh`=1 for exactly one cycle, `cacheline_new` stable; next cycle -> IDLE (`busy` drops).
- **Latency:**
  - Clean miss with zero-wait slave: `miss`@T0 -> AR@T1 -> R beats T2..T9 -> `refresh`@T10 -> IDLE@T11.
  - Dirty miss adds AW(1) + W(8) + B(>=1) cycles.
- **Back-to-back:** a new `miss` may be accepted the cycle `busy` is low, i.e. the cycle after `refresh`.
- **Stability:** `cacheline_new` holds its value after DONE until the next refill overwrites words.
- **Reset mid-burst:** immediate return to IDLE, all valids drop; the outstanding transaction is abandoned. System reset is the only permitted abort.

Test Plan:
- **Clean miss, zero-wait slave:** `miss`=1, `dirty`=0, `miss_addr`=0x0000_1234, rdata beats 0x10..0x17 -> `araddr`=0x0000_1220, `arlen`=7, `refresh`@T10 with `cacheline_new`=0x17..0x10 packed (word0=0x10); AW/W never valid.
- **Dirty miss:** `wb_addr`=0x0000_2040, `cacheline_old` word i=0xA0+i, `miss_addr`=0x0000_3000 -> `awaddr`=0x0000_2040, `wdata` 0xA0..0xA7, `wlast` only on the 0xA7 beat; AR only after `bvalid`; refresh line correct.
- **Backpressure:** `arready` delayed 3 cycles, `wready` toggled every other cycle, `rvalid` gaps -> `araddr`/`wdata` stable while unacknowledged, no lost or duplicated beats, beat order preserved.
- **Early `awready`/`wready` together with a `miss` in a busy state:** `wready`=1 before the AW handshake -> no `wvalid` until AW done; second `miss` during R ignored, only one `refresh`.
- **Async reset during W beat 4:** `rst` pulsed mid-cycle -> outputs 0 immediately, state IDLE; a subsequent clean miss completes normally.
- **Early `rlast` on beat 5:** refill continues to 8 beats; `refresh` only after the 8th `rvalid`.

Source files
------------

// File: rtl/cache_axi_refill.sv
// AXI line engine for the data cache: writes back a dirty victim with an
// 8-beat write burst, then refills the missing line with an 8-beat read burst.
module cache_axi_refill #(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss,
    input  logic                     dirty,
    input  logic [31:0]              miss_addr,
    input  logic [31:0]              wb_addr,
    input  logic [LINE_WORDS*32-1:0] cacheline_old,
    output logic                     refresh,
    output logic [LINE_WORDS*32-1:0] cacheline_new,
    output logic                     busy,
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [3:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [3:0]               wid,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    input  logic [1:0]               bresp,
    output logic                     bready,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [3:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);

    localparam int              BW        = $clog2(LINE_WORDS);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    state_t                  state, state_nx;
    logic [BW-1:0]           beat;
    logic [31:0]             line_addr;
    logic [31:0]             victim_addr;
    logic [LINE_WORDS*32-1:0] old_line;
    logic [LINE_WORDS*32-1:0] new_line;

    // Response codes and rlast carry no information this engine acts on.
    logic unused_ok;
    assign unused_ok = ^{bresp, rresp, rlast, miss_addr[4:0], wb_addr[4:0]};

    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign arid    = AXI_ID;
    assign awlen   = 4'(LINE_WORDS - 1);
    assign arlen   = 4'(LINE_WORDS - 1);
    assign awsize  = 3'b010;
    assign arsize  = 3'b010;
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign wstrb   = 4'hF;

    assign awaddr        = victim_addr;
    assign araddr        = line_addr;
    assign wdata         = old_line[{beat, 5'b0} +: 32];
    assign cacheline_new = new_line;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        wlast    = 1'b0;
        bready   = 1'b0;
        arvalid  = 1'b0;
        rready   = 1'b0;
        refresh  = 1'b0;
        case (state)
            S_IDLE: if (miss) state_nx = dirty ? S_AW : S_AR;
            S_AW: begin
                awvalid = 1'b1;
                if (awready) state_nx = S_W;
            end
            S_W: begin
                wvalid = 1'b1;
                wlast  = (beat == LAST_BEAT);
                if (wready && wlast) state_nx = S_B;
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) state_nx = S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) state_nx = S_R;
            end
            // Termination counts beats; an early rlast must not cut the line short.
            S_R: begin
                rready = 1'b1;
                if (rvalid && beat == LAST_BEAT) state_nx = S_DONE;
            end
            S_DONE: begin
                refresh  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat        <= '0;
            line_addr   <= '0;
            victim_addr <= '0;
            old_line    <= '0;
            new_line    <= '0;
        end else begin
            case (state)
                S_IDLE: if (miss) begin
                    line_addr   <= {miss_addr[31:5], 5'b0};
                    victim_addr <= {wb_addr[31:5], 5'b0};
                    old_line    <= cacheline_old;
                    beat        <= '0;
                end
                S_W: if (wready) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
                S_R: if (rvalid) begin
                    new_line[{beat, 5'b0} +: 32] <= rdata;
                    beat <= beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_refill.sv
// Directed bench for cache_axi_refill: acts as the AXI slave and checks the
// burst addresses, write data order, beat counts and the assembled refill line.
module tb_cache_axi_refill;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss, dirty;
    logic [31:0]  miss_addr, wb_addr;
    logic [255:0] cacheline_old;
    logic         refresh;
    logic [255:0] cacheline_new;
    logic         busy;
    logic [3:0]   awid, wid, arid, awlen, arlen, wstrb;
    logic [31:0]  awaddr, araddr, wdata, rdata;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rlast, rvalid, rready;

    int n_assert = 0;
    int n_fail   = 0;

    cache_axi_refill dut (
        .clk(clk), .rst(rst), .miss(miss), .dirty(dirty),
        .miss_addr(miss_addr), .wb_addr(wb_addr), .cacheline_old(cacheline_old),
        .refresh(refresh), .cacheline_new(cacheline_new), .busy(busy),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        miss = 0; dirty = 0; miss_addr = '0; wb_addr = '0; cacheline_old = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b10; arready = 0;
        rdata = '0; rresp = 2'b10; rlast = 0; rvalid = 0;
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    // One miss from IDLE to refresh (or to a reset abort in the W phase).
    task automatic run_miss(input string name, input logic drt,
                            input logic [31:0] maddr, input logic [31:0] wbaddr,
                            input logic [31:0] old_base, input logic [31:0] rbase,
                            input logic [31:0] exp_araddr, input logic [31:0] exp_awaddr,
                            input int ar_delay, input bit w_toggle, input bit r_gaps,
                            input bit early_rdy, input bit extra_miss,
                            input int rlast_early, input int abort_wbeat, input int exp_t);
        logic [255:0] old_l, exp_l;
        int  wcnt = 0, rcnt = 0, arcnt = 0, bcnt = 0, t = 0;
        bit  aw_done = 0, b_done = 0, fin = 0, refreshed = 0;
        old_l = mk_line(old_base);
        exp_l = mk_line(rbase);
        miss = 1; dirty = drt; miss_addr = maddr; wb_addr = wbaddr; cacheline_old = old_l;
        if (early_rdy) begin awready = 1; wready = 1; end
        chk({name, "_idle_busy"}, busy, 0);
        while (!fin && t < 300) begin
            if (t > 0) begin
                miss = extra_miss && rready;
                if (miss) begin dirty = 1; miss_addr = 32'hDEAD_BEE0; end
            end
            if (!drt) chk({name, "_no_aw_w"}, {awvalid, wvalid}, 0);
            if (!aw_done) chk({name, "_no_w_before_aw"}, wvalid, 0);
            if (drt && !b_done) chk({name, "_no_ar_before_b"}, arvalid, 0);
            if (!early_rdy) awready = awvalid;
            if (awvalid) begin
                chk({name, "_awaddr"}, awaddr, exp_awaddr);
                chk({name, "_awlen"}, awlen, 7);
                if (awready) aw_done = 1;
            end
            if (!early_rdy) wready = w_toggle ? (t % 2 == 1) : 1'b1;
            if (wvalid && abort_wbeat >= 0 && wcnt == abort_wbeat) begin
                wready = 0;
                #2 rst = 1;
                #1;
                chk({name, "_rst_valids"}, {awvalid, wvalid, bready, arvalid, rready, refresh}, 0);
                chk({name, "_rst_busy"}, busy, 0);
                chk({name, "_rst_line"}, cacheline_new, 0);
                #2 rst = 0;
                idle_inputs();
                fin = 1;
            end else begin
                if (wvalid) begin
                    chk({name, "_wdata"}, wdata, old_l[wcnt*32 +: 32]);
                    chk({name, "_wlast"}, wlast, (wcnt == 7));
                    if (wready) wcnt++;
                end
                bvalid = bready && (bcnt >= 1);
                if (bready) bcnt++;
                if (bvalid) begin
                    b_done = 1;
                    chk({name, "_wbeats"}, wcnt, 8);
                end
                if (arvalid) begin
                    chk({name, "_araddr"}, araddr, exp_araddr);
                    chk({name, "_arlen"}, arlen, 7);
                    arready = (arcnt >= ar_delay);
                    arcnt++;
                end else arready = 0;
                rvalid = rready && !(r_gaps && (t % 3 == 0));
                rdata  = rbase + 32'(rcnt);
                rlast  = rvalid && (rcnt == 7 || rcnt == rlast_early);
                if (rvalid) rcnt++;
                if (refresh) begin
                    chk({name, "_rbeats"}, rcnt, 8);
                    chk({name, "_line"}, cacheline_new, exp_l);
                    if (exp_t >= 0) chk({name, "_latency"}, t, exp_t);
                    fin = 1;
                    refreshed = 1;
                end
            end
            if (!fin || refreshed) begin
                cyc();
                t++;
            end
        end
        if (!fin) chk({name, "_timeout"}, 0, 1);
        if (refreshed) begin
            chk({name, "_single_refresh"}, {refresh, busy}, 0);
            idle_inputs();
            cyc();
            chk({name, "_line_stable"}, cacheline_new, exp_l);
            chk({name, "_still_idle"}, busy, 0);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("in_reset_valids", {awvalid, wvalid, bready, arvalid, rready, refresh, busy}, 0);
        #4 rst = 0;
        cyc();
        chk("reset_busy", busy, 0);
        chk("reset_valids", {awvalid, wvalid, bready, arvalid, rready, refresh}, 0);
        chk("reset_line", cacheline_new, 0);
        chk("const_len", {awlen, arlen}, 8'h77);
        chk("const_size", {awsize, arsize}, 6'b010010);
        chk("const_burst", {awburst, arburst}, 4'b0101);
        chk("const_strb", wstrb, 4'hF);
        chk("const_ids", {awid, wid, arid}, 12'h000);

        run_miss("clean", 1'b0, 32'h0000_1234, 32'h0, 32'h0, 32'h10,
                 32'h0000_1220, 32'h0, 0, 0, 0, 0, 0, -1, -1, 10);
        run_miss("dirty", 1'b1, 32'h0000_3000, 32'h0000_2040, 32'hA0, 32'h20,
                 32'h0000_3000, 32'h0000_2040, 0, 0, 0, 0, 0, -1, -1, 21);
        run_miss("bp", 1'b1, 32'h0000_4ABC, 32'h0000_5F3F, 32'hB0, 32'h30,
                 32'h0000_4AA0, 32'h0000_5F20, 3, 1, 1, 0, 0, -1, -1, -1);
        run_miss("early", 1'b1, 32'h6000_0000, 32'h7000_001F, 32'hC0, 32'h40,
                 32'h6000_0000, 32'h7000_0000, 0, 0, 0, 1, 1, -1, -1, -1);
        run_miss("abort", 1'b1, 32'h1111_1100, 32'h2222_2200, 32'hD0, 32'h0,
                 32'h1111_1100, 32'h2222_2200, 0, 0, 0, 0, 0, -1, 4, -1);
        run_miss("post_rst", 1'b0, 32'h8000_0044, 32'h0, 32'h0, 32'h50,
                 32'h8000_0040, 32'h0, 0, 0, 0, 0, 0, -1, -1, 10);
        run_miss("rlast5", 1'b0, 32'h9FFF_FFE0, 32'h0, 32'h0, 32'h60,
                 32'h9FFF_FFE0, 32'h0, 0, 0, 0, 0, 0, 4, -1, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
